// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data RAM port: CPU (C) has fixed priority, D may lock the port for bursts.
// Optional starvation guard for D is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int unsigned AW         = 14,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          c_req,
    input  logic [3:0]    c_wmask,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_lock,
    input  logic [3:0]    d_wmask,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK_D
    } state_t;

    state_t r_state;
    logic   r_rvalid;
    logic   r_owner_d;
    logic   w_c_gnt;
    logic   w_d_gnt;
    logic   w_starve_win;

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] r_starve_cnt;
    assign w_starve_win = (r_starve_cnt == 8'(STARVE_MAX));
`else
    logic w_unused_starve_max;
    assign w_unused_starve_max = |8'(STARVE_MAX);
    assign w_starve_win = 1'b0;
`endif

    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (resetn) begin
            if (r_state == ST_LOCK_D) begin
                w_d_gnt = d_req;
            end else if (c_req && d_req && w_starve_win) begin
                w_d_gnt = 1'b1;
            end else if (c_req) begin
                w_c_gnt = 1'b1;
            end else begin
                w_d_gnt = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_rvalid  <= 1'b0;
            r_owner_d <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
            r_starve_cnt <= '0;
`endif
        end else begin
            r_rvalid  <= (w_c_gnt && (c_wmask == 4'd0)) || (w_d_gnt && (d_wmask == 4'd0));
            r_owner_d <= w_d_gnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_d_gnt && d_lock) r_state <= ST_LOCK_D;
                end
                ST_LOCK_D: begin
                    if ((w_d_gnt && !d_lock) || (!d_req && !d_lock)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef DMEM_ARB_STARVE_EN
            if (w_d_gnt || !d_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != 8'hFF) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
`endif
        end
    end

    assign c_gnt     = w_c_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_c_gnt | w_d_gnt;
    assign mem_wmask = w_c_gnt ? c_wmask : (w_d_gnt ? d_wmask : 4'd0);
    assign mem_addr  = w_d_gnt ? d_addr  : c_addr;
    assign mem_wdata = w_d_gnt ? d_wdata : c_wdata;

    // The owner bit steers the returning read word to the port that issued it.
    assign c_rvalid = r_rvalid & ~r_owner_d;
    assign d_rvalid = r_rvalid &  r_owner_d;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first, byte-masked RAM model on the memory port.
module tb_dmem_arbiter;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          resetn;
    logic          c_req;
    logic [3:0]    c_wmask;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [31:0]   c_rdata;
    logic          d_req;
    logic          d_lock;
    logic [3:0]    d_wmask;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] ram_word;

    dmem_arbiter #(.AW(AW), .STARVE_MAX(8)) dut (
        .clk(clk), .resetn(resetn),
        .c_req(c_req), .c_wmask(c_wmask), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Write-first RAM: a masked write is merged and returned on the same access.
    always @(posedge clk) begin
        if (mem_en) begin
            ram_word = ram[mem_addr];
            for (int unsigned b = 0; b < 4; b++)
                if (mem_wmask[b]) ram_word[8*b +: 8] = mem_wdata[8*b +: 8];
            ram[mem_addr] <= ram_word;
            mem_rdata     <= ram_word;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic req, input logic [3:0] wm, input logic [AW-1:0] a, input logic [31:0] wd);
        c_req = req; c_wmask = wm; c_addr = a; c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic lk, input logic [3:0] wm, input logic [AW-1:0] a, input logic [31:0] wd);
        d_req = req; d_lock = lk; d_wmask = wm; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        for (int unsigned i = 0; i < (1 << AW); i++) ram[i] = '0;
        mem_rdata = '0;
        resetn = 1'b0;
        set_c(1'b1, 4'h0, 14'h000, 32'h0);
        set_d(1'b1, 1'b0, 4'h0, 14'h000, 32'h0);

        // Reset held three cycles with both ports requesting
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("rst_c_gnt", c_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_c_rvalid", c_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
        end

        tick(); resetn = 1'b1; #1;
        chk("rel_c_gnt", c_gnt, 1);
        chk("rel_d_gnt", d_gnt, 0);

        // C full write 0x010
        tick(); set_c(1'b1, 4'hF, 14'h010, 32'hDEADBEEF); set_d(1'b0, 1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("cw_gnt", c_gnt, 1);
        chk("cw_wmask", mem_wmask, 32'hF);
        chk("cw_addr", mem_addr, 32'h010);
        chk("cw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("cw_prev_rvalid", c_rvalid, 1);
        chk("cw_prev_rdata", c_rdata, 0);

        // C read back next cycle: write-first returns the new word
        tick(); set_c(1'b1, 4'h0, 14'h010, 32'h0); #1;
        chk("cr_gnt", c_gnt, 1);
        chk("cr_wr_no_rvalid", c_rvalid, 0);
        tick(); set_c(1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("cr_rvalid", c_rvalid, 1);
        chk("cr_rdata", c_rdata, 32'hDEADBEEF);
        chk("cr_d_rvalid", d_rvalid, 0);
        chk("cr_d_rdata", d_rdata, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_wmask", mem_wmask, 0);

        // Partial write of the low half-word
        tick(); set_c(1'b1, 4'h3, 14'h010, 32'h12345678); #1;
        chk("cpw_gnt", c_gnt, 1);
        chk("cpw_wmask", mem_wmask, 32'h3);

        // D writes 0x020 alone
        tick(); set_c(1'b0, 4'h0, 14'h000, 32'h0); set_d(1'b1, 1'b0, 4'hF, 14'h020, 32'hA5A5A5A5); #1;
        chk("dw_gnt", d_gnt, 1);
        chk("dw_c_gnt", c_gnt, 0);
        chk("dw_addr", mem_addr, 32'h020);

        // Contention: both read, C wins, then D
        tick(); set_c(1'b1, 4'h0, 14'h010, 32'h0); set_d(1'b1, 1'b0, 4'h0, 14'h020, 32'h0); #1;
        chk("ct0_c_gnt", c_gnt, 1);
        chk("ct0_d_gnt", d_gnt, 0);
        chk("ct0_addr", mem_addr, 32'h010);
        tick(); set_c(1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("ct1_d_gnt", d_gnt, 1);
        chk("ct1_c_gnt", c_gnt, 0);
        chk("ct1_addr", mem_addr, 32'h020);
        chk("ct1_c_rvalid", c_rvalid, 1);
        chk("ct1_c_rdata", c_rdata, 32'hDEAD5678);
        chk("ct1_d_rvalid", d_rvalid, 0);
        tick(); set_d(1'b0, 1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("ct2_d_rvalid", d_rvalid, 1);
        chk("ct2_d_rdata", d_rdata, 32'hA5A5A5A5);
        chk("ct2_c_rvalid", c_rvalid, 0);
        chk("ct2_c_rdata", c_rdata, 0);

        // Locked 4-beat D write burst; C requests from beat 2 on
        for (int i = 0; i < 4; i++) begin
            tick();
            set_d(1'b1, (i < 3), 4'hF, 14'(32'h100 + i), 32'hB0000000 + i);
            if (i > 0) set_c(1'b1, 4'h0, 14'h010, 32'h0);
            #1;
            chk("lk_d_gnt", d_gnt, 1);
            chk("lk_c_gnt", c_gnt, 0);
            chk("lk_addr", mem_addr, 32'h100 + i);
        end
        tick(); set_d(1'b0, 1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("lk_end_c_gnt", c_gnt, 1);
        chk("lk_end_d_gnt", d_gnt, 0);

        // Lock with idle hold, then release via !d_req & !d_lock
        tick(); set_c(1'b0, 4'h0, 14'h000, 32'h0); set_d(1'b1, 1'b1, 4'h0, 14'h102, 32'h0); #1;
        chk("hold_d_gnt", d_gnt, 1);
        tick(); set_c(1'b1, 4'h0, 14'h010, 32'h0); set_d(1'b0, 1'b1, 4'h0, 14'h000, 32'h0); #1;
        chk("hold_c_gnt", c_gnt, 0);
        chk("hold_d_rvalid", d_rvalid, 1);
        chk("hold_d_rdata", d_rdata, 32'hB0000002);
        tick(); set_d(1'b0, 1'b0, 4'h0, 14'h000, 32'h0); #1;
        chk("unlock_c_gnt", c_gnt, 0);
        tick(); #1;
        chk("unlock2_c_gnt", c_gnt, 1);

        // Both request continuously
        tick(); set_d(1'b1, 1'b0, 4'h0, 14'h020, 32'h0); #1;
        for (int k = 1; k <= 18; k++) begin
`ifdef DMEM_ARB_STARVE_EN
            chk("stv_d_gnt", d_gnt, (k == 9 || k == 18));
            chk("stv_c_gnt", c_gnt, !(k == 9 || k == 18));
`else
            chk("stv_d_gnt", d_gnt, 0);
            chk("stv_c_gnt", c_gnt, 1);
`endif
            tick(); #1;
        end

        // Reset while D is locked and reading
        set_c(1'b0, 4'h0, 14'h000, 32'h0); set_d(1'b1, 1'b1, 4'h0, 14'h020, 32'h0); #1;
        chk("rm_d_gnt", d_gnt, 1);
        tick(); resetn = 1'b0; #1;
        chk("rm_rst_d_gnt", d_gnt, 0);
        chk("rm_rst_mem_en", mem_en, 0);
        tick(); resetn = 1'b1; set_c(1'b1, 4'h0, 14'h010, 32'h0); #1;
        chk("rm_d_rvalid", d_rvalid, 0);
        chk("rm_c_gnt_idle", c_gnt, 1);
        chk("rm_d_gnt_idle", d_gnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
